serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller. Drives one internal 1-bit full-adder cell
//  over WIDTH clock cycles, LSB first, to produce a WIDTH-bit sum and carry-out.
//  Trades area for latency. Sits between a requester (start/done handshake)
//  and the shared 1-bit adder datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A; captured on accepted start
//  b      in   WIDTH  operand B; captured on accepted start
//  cin    in   1      carry-in; captured on accepted start
//  busy   out  1      high while serial add in progress (RUN)
//  done   out  1      one-cycle pulse: sum/cout valid
//  sum    out  WIDTH  registered result; held until next done
//  cout   out  1      registered carry-out; held with sum
// BEHAVIOUR
//  - Clocking/reset: one clock (clk); rst is synchronous, active-high.
//  - Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; shift regs, carry
//    flop and bit counter cleared.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE -> RUN when start=1: load a_sh<=a, b_sh<=b, c_q<=cin, cnt<=0.
//    RUN: each cycle the FA takes a_sh[0], b_sh[0], c_q.
//      Its sum bit enters s_sh at MSB, shifting s_sh right.
//      c_q<=FA carry; a_sh/b_sh shift right; cnt<=cnt+1.
//    RUN -> DONE on the cycle cnt==WIDTH-1; sum<=final s_sh; cout<=final carry.
//    DONE -> IDLE unconditionally after one cycle.
//  - Outputs: busy=1 iff state==RUN; done=1 iff state==DONE.
//  - Latency: start sampled at edge N -> busy high after N through edge N+WIDTH.
//    done high for the single cycle after edge N+WIDTH. Throughput: one add
//    per WIDTH+2 cycles.
//  - Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1).
//  - start while RUN or DONE: ignored, no queuing; operands not re-captured.
//  - a/b/cin changes after capture: no effect on the add in flight.
//  - sum/cout change only on RUN->DONE and on rst; stable in IDLE.
//  - rst mid-RUN: abort, next cycle IDLE; outputs return to reset values.
//    No done pulse for the aborted op.
//  - rst and start in same cycle: rst wins; start is dropped.
//  - cnt width = $clog2(WIDTH); no wrap, since RUN exits at WIDTH-1.
// CONFIGURATION
//  SERIAL_ADD_OVF_EN defined: adds output port ovf (out, 1).
//    ovf = signed overflow = (carry into MSB) ^ (carry out of MSB).
//    ovf registered with sum/cout on RUN->DONE; reset 0.
//  Not defined: ovf port and logic absent; all other behaviour identical.
// TESTING
//  T1 WIDTH=8, a=0x5A b=0x33 cin=0, start 1 cycle -> done 8 edges later;
//     sum=0x8D, cout=0.
//  T2 a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; a=0xFF b=0x00 cin=1 ->
//     sum=0x00 cout=1.
//  T3 start held high continuously with changing operands -> one done per
//     10 cycles; each result matches operands captured at its own acceptance.
//  T4 rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0.
//     No done pulse; next start completes normally.
//  T5 rst=1 and start=1 same edge -> stays IDLE, busy=0.
//  T6 SERIAL_ADD_OVF_EN: a=0x7F b=0x01 -> sum=0x80 ovf=1;
//     a=0x80 b=0x80 -> sum=0x00 cout=1 ovf=1; a=0x10 b=0x20 -> ovf=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, one 1-bit full adder reused LSB first over WIDTH cycles
// Ports: clk, rst (sync, active-high), start/a/b/cin request in, busy/done status out,
//   sum/cout registered result (held until next done).
// Optional: define SERIAL_ADD_OVF_EN to add output ovf (signed overflow, registered with sum).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last;
  assign fa_s = a_sh[0] ^ b_sh[0] ^ c_q;
  assign fa_c = (a_sh[0] & b_sh[0]) | (c_q & (a_sh[0] ^ b_sh[0]));
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          c_q   <= cin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= {fa_s, s_sh[WIDTH-1:1]};
          c_q  <= fa_c;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            sum   <= {fa_s, s_sh[WIDTH-1:1]};
            cout  <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
            // c_q is the carry into the MSB on the final bit
            ovf   <= c_q ^ fa_c;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: vector table, random model checks and handshake corner cases for serial_add_ctrl
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic         clk = 0, rst = 1, start = 0, cin_i = 0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif
  int checks = 0, errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .cin(cin_i),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout, ovf;
  } vec_t;

  function automatic logic [W:0] ref_add(logic [W-1:0] x, logic [W-1:0] y, logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return (W+1)'(s);
  endfunction

  function automatic logic ref_ovf(logic [W-1:0] x, logic [W-1:0] y, logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a_i = x; b_i = y; cin_i = c; start = 1;
    @(posedge clk); #1;
    start = 0; a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
    chk("busy_after_accept", busy, 1);
    repeat (W - 1) @(posedge clk);
    #1;
    chk("busy_last_run", busy, 1);
    chk("no_early_done", done, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    chk("sum", sum, es);
    chk("cout", cout, ec);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", ovf, eo);
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("sum_held", sum, es);
  endtask

  initial begin
    vec_t vecs[9];
    logic [W-1:0] ha[64], hb[64];
    logic         hc[64];
    int ndone;
    logic [W:0] r;
    vecs[0] = '{8'h5A, 8'h33, 0, 8'h8D, 0, 1};
    vecs[1] = '{8'hFF, 8'h01, 0, 8'h00, 1, 0};
    vecs[2] = '{8'hFF, 8'h00, 1, 8'h00, 1, 0};
    vecs[3] = '{8'h7F, 8'h01, 0, 8'h80, 0, 1};
    vecs[4] = '{8'h80, 8'h80, 0, 8'h00, 1, 1};
    vecs[5] = '{8'h10, 8'h20, 0, 8'h30, 0, 0};
    vecs[6] = '{8'h00, 8'h00, 0, 8'h00, 0, 0};
    vecs[7] = '{8'h00, 8'h00, 1, 8'h01, 0, 0};
    vecs[8] = '{8'hFF, 8'hFF, 1, 8'hFF, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst = 0;

    foreach (vecs[i])
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x, y;
      logic c;
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      r = ref_add(x, y, c);
      do_add(x, y, c, r[W-1:0], r[W], ref_ovf(x, y, c));
    end

    // start held high with fresh operands every cycle
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ha[c] = W'($urandom); hb[c] = W'($urandom); hc[c] = 1'($urandom);
      a_i = ha[c]; b_i = hb[c]; cin_i = hc[c]; start = 1;
      @(posedge clk); #1;
      chk("held_done_timing", done, (c % (W + 2)) == W);
      if (done) begin
        ndone++;
        if (c >= W) begin
          r = ref_add(ha[c-W], hb[c-W], hc[c-W]);
          chk("held_sum", sum, r[W-1:0]);
          chk("held_cout", cout, r[W]);
        end
      end
    end
    @(negedge clk);
    start = 0;
    chk("held_done_count", ndone, 4);

    // reset mid-RUN aborts with no done pulse
    do_add(8'hFF, 8'hFF, 0, 8'hFE, 1, 0);
    @(negedge clk);
    a_i = 8'h12; b_i = 8'h34; cin_i = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    ndone = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_add(8'h12, 8'h34, 0, 8'h46, 0, 0);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1; start = 1; a_i = 8'h01; b_i = 8'h01;
    @(posedge clk); #1;
    rst = 0; start = 0;
    chk("rst_start_busy", busy, 0);
    @(posedge clk); #1;
    chk("rst_start_idle", busy, 0);
    repeat (W) @(posedge clk);
    #1;
    chk("rst_start_no_done", done, 0);
    chk("rst_start_sum", sum, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
